mem_port_arbiter: RTL and testbench

Arbiter that shares the single unified 1024×32 instruction/data memory of the 5-stage MIPS32 pipeline between two requesters: the instruction-fetch stage (IF) and the memory stage (DM, for loads and stores). It grants at most one access per cycle, drives the memory port, and routes read data back to whichever requester issued the read. It produces per-requester stall outputs, which the pipeline uses to freeze its enable. Data accesses have priority, and a bounded starvation guard ensures fetch still makes forward progress.

---
 rtl/mips32_pkg.sv | 21 ++
 rtl/mem_arb_starve_ctr.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// ============================================================================
// Module      : mips32_pkg
// Description : Shared widths and read-owner encoding for the MIPS32 memory port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mips32_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } rd_owner_t;

endpackage : mips32_pkg

`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
// ============================================================================
// Module      : mem_arb_starve_ctr
// Description : Saturating count of DM grants taken while IF waits; raises
//               force_if once the count reaches STARVE_MAX.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arb_starve_ctr
    import mips32_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic dm_gnt,
    output logic force_if
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!if_req || if_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (dm_gnt && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign force_if = (r_starve_cnt == c_STARVE_MAX);

endmodule : mem_arb_starve_ctr

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one synchronous-read memory port between IF and DM,
//               DM priority, read data routed back to the issuing requester.
//               Optional macro ARB_STARVE_GUARD_EN enables the IF starvation guard.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mips32_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [MEM_ADDR_W-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [MEM_ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  if_stall,
    output logic                  dm_stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    logic      w_force_if;
    logic      w_if_gnt;
    logic      w_dm_gnt;
    rd_owner_t r_rd_owner;

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_gnt   (w_if_gnt),
        .dm_gnt   (w_dm_gnt),
        .force_if (w_force_if)
    );
`else
    logic w_unused_starve_max;
    assign w_unused_starve_max = (STARVE_MAX == 0);
    assign w_force_if          = 1'b0;
`endif

    // force_if only matters when both sides are requesting
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (rst_n) begin
            if (dm_req && !(if_req && w_force_if)) begin
                w_dm_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign dm_gnt    = w_dm_gnt;
    assign if_stall  = rst_n & if_req & ~w_if_gnt;
    assign dm_stall  = rst_n & dm_req & ~w_dm_gnt;

    assign mem_en    = w_if_gnt | w_dm_gnt;
    assign mem_we    = w_dm_gnt & dm_we;
    assign mem_addr  = w_dm_gnt ? dm_addr  : (w_if_gnt ? if_addr : '0);
    assign mem_wdata = w_dm_gnt ? dm_wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_owner <= OWN_NONE;
        end else if (w_dm_gnt && !dm_we) begin
            r_rd_owner <= OWN_DM;
        end else if (w_if_gnt) begin
            r_rd_owner <= OWN_IF;
        end else begin
            r_rd_owner <= OWN_NONE;
        end
    end

    // Reset gating here kills a read still in flight when reset arrives
    assign if_rvalid = rst_n && (r_rd_owner == OWN_IF);
    assign dm_rvalid = rst_n && (r_rd_owner == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               1024x32 synchronous-read memory model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int unsigned c_STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit c_GUARD = 1'b1;
`else
    localparam bit c_GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [9:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        if_stall;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .STARVE_MAX (c_STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .if_stall  (if_stall),
        .dm_stall  (dm_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are applied
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle point for sampling outputs of the current cycle
    task automatic settle();
        #3;
    endtask

    function automatic logic [7:0] flags();
        return {if_gnt, dm_gnt, mem_en, mem_we, if_stall, dm_stall, if_rvalid, dm_rvalid};
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[5] = 32'hDEADBEEF;
        mem[7] = 32'h0707A5A5;
        mem[8] = 32'h08085A5A;

        rst_n = 1'b0; if_req = 1'b1; if_addr = 10'd2;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd1; dm_wdata = 32'hFFFF0000;

        // Reset held for 3 cycles with both requests high
        for (int i = 0; i < 3; i++) begin
            step(); settle();
            chk("rst_flags", {24'd0, flags()}, 32'd0);
            chk("rst_addr", {22'd0, mem_addr}, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
        end
        step(); rst_n = 1'b1; settle();
        chk("rel_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        chk("rel_if_stall", {31'd0, if_stall}, 32'd1);
        step(); if_req = 1'b0; dm_req = 1'b0; settle();
        chk("idle_mem_en", {31'd0, mem_en}, 32'd0);

        // IF read only
        step(); if_req = 1'b1; if_addr = 10'd5; settle();
        chk("if_rd_gnt", {31'd0, if_gnt}, 32'd1);
        chk("if_rd_addr", {22'd0, mem_addr}, 32'd5);
        chk("if_rd_we", {31'd0, mem_we}, 32'd0);
        step(); if_req = 1'b0; settle();
        chk("if_rd_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("if_rd_rdata", if_rdata, 32'hDEADBEEF);
        chk("if_rd_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
        chk("if_rd_dm_rdata", dm_rdata, 32'd0);

        // Contention: both requests held for two guard windows
        if_addr = 10'd4; dm_addr = 10'd3;
        for (int i = 0; i < 10; i++) begin
            step(); if_req = 1'b1; dm_req = 1'b1; settle();
            chk("cont_if_gnt", {31'd0, if_gnt}, {31'd0, c_GUARD && (i % 5 == 4)});
            chk("cont_dm_gnt", {31'd0, dm_gnt}, {31'd0, !(c_GUARD && (i % 5 == 4))});
            chk("cont_if_stall", {31'd0, if_stall}, {31'd0, !(c_GUARD && (i % 5 == 4))});
        end
        step(); if_req = 1'b0; dm_req = 1'b0;

        // Store then load of the same address
        step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd20; dm_wdata = 32'h12345678; settle();
        chk("st_gnt", {31'd0, dm_gnt}, 32'd1);
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_wdata", mem_wdata, 32'h12345678);
        step(); dm_we = 1'b0; settle();
        chk("ld_gnt", {31'd0, dm_gnt}, 32'd1);
        chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
        chk("st_no_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        step(); dm_req = 1'b0; settle();
        chk("ld_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("ld_rdata", dm_rdata, 32'h12345678);
        chk("ld_if_rvalid", {31'd0, if_rvalid}, 32'd0);

        // Alternating owners back to back
        step(); dm_req = 1'b1; dm_addr = 10'd7; settle();
        chk("alt_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        step(); dm_req = 1'b0; if_req = 1'b1; if_addr = 10'd8; settle();
        chk("alt_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("alt_dm_rdata", dm_rdata, 32'h0707A5A5);
        chk("alt_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
        chk("alt_if_quiet", {if_rdata[30:0], if_rvalid}, 32'd0);
        step(); if_req = 1'b0; settle();
        chk("alt_if_rdata", if_rdata, 32'h08085A5A);
        chk("alt_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("alt_dm_quiet", {dm_rdata[30:0], dm_rvalid}, 32'd0);

        // Reset mid-read after the starvation count has built up
        for (int i = 0; i < 3; i++) begin
            step(); if_req = 1'b1; dm_req = 1'b1; dm_addr = 10'd7; settle();
            chk("pre_rst_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        end
        step(); rst_n = 1'b0; settle();
        chk("mid_rst_flags", {24'd0, flags()}, 32'd0);
        chk("mid_rst_rdata", dm_rdata, 32'd0);
        step(); rst_n = 1'b1; settle();
        chk("post_rst_rvalid", {31'd0, dm_rvalid}, 32'd0);
        // A cleared counter gives DM a full window again
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                step(); settle();
            end
            chk("post_rst_if_gnt", {31'd0, if_gnt}, {31'd0, c_GUARD && (i == 4)});
        end
        step(); if_req = 1'b0; dm_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter

`default_nettype wire
